// File: rtl/concat_rotate_compare.sv
// concat_rotate_compare
// Compares the natural concatenation X = {a,b,c} with the rotated concatenation
// Y = {b,c,a} as unsigned values. Equality, greater-than and less-than flags and
// both concatenations are registered, with out_valid qualifying them one cycle
// after in_valid. Equality holds exactly when all three lanes carry the same value.
module concat_rotate_compare #(
   parameter int WIDTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   output logic               out_valid,
   output logic               result,
   output logic               gt,
   output logic               lt,
   output logic [3*WIDTH-1:0] abc,
   output logic [3*WIDTH-1:0] bca
);

   localparam int XW = 3 * WIDTH;

   logic [XW-1:0] x_next;
   logic [XW-1:0] y_next;
   logic          eq_next;
   logic          gt_next;
   logic          lt_next;

   logic          out_valid_reg;
   logic          result_reg;
   logic          gt_reg;
   logic          lt_reg;
   logic [XW-1:0] abc_reg;
   logic [XW-1:0] bca_reg;

   // Place each operand into its field of both concatenations, one lane per
   // generate iteration: lane 0 is the top field, lane 2 the bottom field.
   logic [WIDTH-1:0] x_field [3];
   logic [WIDTH-1:0] y_field [3];

   assign x_field[0] = a;
   assign x_field[1] = b;
   assign x_field[2] = c;
   assign y_field[0] = b;
   assign y_field[1] = c;
   assign y_field[2] = a;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_field
         assign x_next[(3-gi)*WIDTH-1 -: WIDTH] = x_field[gi];
         assign y_next[(3-gi)*WIDTH-1 -: WIDTH] = y_field[gi];
      end
   endgenerate

   // Full-width unsigned compare ahead of the output register; the three flags
   // are mutually exclusive by construction.
   always_comb begin
      eq_next = 1'b0;
      gt_next = 1'b0;
      lt_next = 1'b0;
      if (x_next == y_next) begin
         eq_next = 1'b1;
      end else if (x_next > y_next) begin
         gt_next = 1'b1;
      end else begin
         lt_next = 1'b1;
      end
   end

   // Output register: reset wins over in_valid; without in_valid the data
   // outputs hold and only out_valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         result_reg    <= 1'b0;
         gt_reg        <= 1'b0;
         lt_reg        <= 1'b0;
         abc_reg       <= '0;
         bca_reg       <= '0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            result_reg <= eq_next;
            gt_reg     <= gt_next;
            lt_reg     <= lt_next;
            abc_reg    <= x_next;
            bca_reg    <= y_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign gt        = gt_reg;
   assign lt        = lt_reg;
   assign abc       = abc_reg;
   assign bca       = bca_reg;

endmodule

// File: tb/tb_concat_rotate_compare.sv
// Self-checking bench for concat_rotate_compare at WIDTH=2.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// 1 time unit after the edge that registers them.
module tb_concat_rotate_compare;

   localparam int WIDTH = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   c;
   logic               out_valid;
   logic               result;
   logic               gt;
   logic               lt;
   logic [3*WIDTH-1:0] abc;
   logic [3*WIDTH-1:0] bca;

   int checks = 0;
   int errors = 0;

   concat_rotate_compare #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .result    (result),
      .gt        (gt),
      .lt        (lt),
      .abc       (abc),
      .bca       (bca)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held for two edges while valid operands are presented; then the
   // first valid result appears one edge after reset is released.
   task automatic test_reset();
      logic [9:0] obs;
      rst = 1'b1; in_valid = 1'b1; a = 2'd3; b = 2'd3; c = 2'd3;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {out_valid, result, gt, lt, abc};
         checks++;
         if (obs !== 10'd0 || bca !== 6'd0) begin
            errors++;
            $display("FAIL reset_cycle%0d: got ov=%b res=%b gt=%b lt=%b abc=%b bca=%b, required all 0",
                     i, out_valid, result, gt, lt, abc, bca);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({out_valid, result, gt, lt} !== 4'b1100 || abc !== 6'b111111 || bca !== 6'b111111) begin
         errors++;
         $display("FAIL reset_release: got ov=%b res=%b gt=%b lt=%b abc=%b bca=%b, required ov=1 res=1 gt=0 lt=0 abc=bca=111111",
                  out_valid, result, gt, lt, abc, bca);
      end
      $display("txn reset: ov=%b res=%b abc=%b", out_valid, result, abc);
   endtask

   // Three directed vectors, each separated by an idle cycle.
   task automatic test_directed();
      logic [1:0] va [3]  = '{2'b01, 2'b11, 2'b10};
      logic [1:0] vb [3]  = '{2'b10, 2'b00, 2'b10};
      logic [1:0] vc [3]  = '{2'b11, 2'b01, 2'b10};
      logic [5:0] eabc [3] = '{6'b011011, 6'b110001, 6'b101010};
      logic [5:0] ebca [3] = '{6'b101101, 6'b000111, 6'b101010};
      logic [2:0] eflg [3] = '{3'b001, 3'b010, 3'b100}; // {result, gt, lt}
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = va[i]; b = vb[i]; c = vc[i];
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || {result, gt, lt} !== eflg[i] || abc !== eabc[i] || bca !== ebca[i]) begin
            errors++;
            $display("FAIL directed%0d: got ov=%b flags=%b abc=%b bca=%b, required ov=1 flags=%b abc=%b bca=%b",
                     i, out_valid, {result, gt, lt}, abc, bca, eflg[i], eabc[i], ebca[i]);
         end
         $display("txn directed%0d: a=%b b=%b c=%b -> flags=%b abc=%b bca=%b",
                  i, va[i], vb[i], vc[i], {result, gt, lt}, abc, bca);
         tick();
      end
   endtask

   // Consecutive vectors, then idle with changing operands: outputs must hold.
   task automatic test_back_to_back();
      logic [1:0] va [3] = '{2'b01, 2'b11, 2'b10};
      logic [1:0] vb [3] = '{2'b10, 2'b00, 2'b10};
      logic [1:0] vc [3] = '{2'b11, 2'b01, 2'b10};
      logic       eres [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = va[i]; b = vb[i]; c = vc[i];
         tick();
         checks++;
         if (out_valid !== 1'b1 || result !== eres[i]) begin
            errors++;
            $display("FAIL b2b%0d: got ov=%b res=%b, required ov=1 res=%b", i, out_valid, result, eres[i]);
         end
         $display("txn b2b%0d: ov=%b res=%b", i, out_valid, result);
      end
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b0; a = 2'(i); b = 2'(i + 2); c = 2'b11;
         tick();
         checks++;
         if (out_valid !== 1'b0 || {result, gt, lt} !== 3'b100 || abc !== 6'b101010 || bca !== 6'b101010) begin
            errors++;
            $display("FAIL hold%0d: got ov=%b flags=%b abc=%b bca=%b, required ov=0 flags=100 abc=bca=101010",
                     i, out_valid, {result, gt, lt}, abc, bca);
         end
         $display("txn hold%0d: ov=%b res=%b abc=%b", i, out_valid, result, abc);
      end
   endtask

   // Reset asserted alongside valid operands discards them.
   task automatic test_reset_midstream();
      in_valid = 1'b1; a = 2'b00; b = 2'b01; c = 2'b10;
      tick();
      rst = 1'b1; a = 2'b11; b = 2'b11; c = 2'b11;
      tick();
      checks++;
      if ({out_valid, result, gt, lt} !== 4'b0000 || abc !== 6'd0 || bca !== 6'd0) begin
         errors++;
         $display("FAIL reset_midstream: got ov=%b flags=%b abc=%b bca=%b, required all 0",
                  out_valid, {result, gt, lt}, abc, bca);
      end
      $display("txn reset_midstream: ov=%b abc=%b", out_valid, abc);
      rst = 1'b0; in_valid = 1'b0;
      tick();
   endtask

   // Streamed sweep of all 64 operand combinations against a reference model.
   task automatic test_exhaustive();
      logic [5:0] ex, ey;
      logic       eeq, egt, elt;
      int         sweep_err = 0;
      for (int i = 0; i < 64; i++) begin
         a = 2'(i >> 4); b = 2'(i >> 2); c = 2'(i); in_valid = 1'b1;
         ex  = {a, b, c};
         ey  = {b, c, a};
         eeq = (a == b) && (b == c);
         egt = ex > ey;
         elt = ex < ey;
         tick();
         checks++;
         if (out_valid !== 1'b1 || abc !== ex || bca !== ey || result !== eeq ||
             gt !== egt || lt !== elt || (32'(result) + 32'(gt) + 32'(lt)) != 1) begin
            errors++;
            sweep_err++;
            $display("FAIL sweep a=%b b=%b c=%b: got ov=%b flags=%b abc=%b bca=%b, required ov=1 flags=%b abc=%b bca=%b",
                     a, b, c, out_valid, {result, gt, lt}, abc, bca, {eeq, egt, elt}, ex, ey);
         end
      end
      in_valid = 1'b0;
      tick();
      $display("txn sweep: 64 combinations, %0d mismatching", sweep_err);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
      #1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
